data_ram_arbiter: RTL

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/definitions_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 19 +
 rtl/data_ram_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// definitions_pkg: shared word types, data RAM geometry and arbiter FSM encoding
package definitions_pkg;

    typedef logic [31:0]        word_ut;
    typedef logic signed [31:0] word_st;

    localparam int DATA_SIZE = 1024;
    localparam int N_PORTS   = 2;
    localparam int PORT_W    = 1;
    localparam int BE_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MERGE,
        WRITE
    } arb_state_e;

    // Byte-lane merge: enabled lanes take the new data, the rest keep the RAM word
    function automatic word_st merge_lanes(input logic [BE_W-1:0] be, input word_st wd, input word_st rd);
        word_st m;
        for (int k = 0; k < BE_W; k++) m[8*k +: 8] = be[k] ? wd[8*k +: 8] : rd[8*k +: 8];
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: two-port round-robin pick, priority port first, one-hot grant
module rr_arbiter
    import definitions_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  prio,
    output logic [N_PORTS-1:0] gnt
);

    logic [PORT_W-1:0] other;

    assign other = ~prio;

    // priority port wins if requesting, otherwise the other port if it requests
    always_comb begin
        gnt = req[prio] ? N_PORTS'(1) << prio : req[other] ? N_PORTS'(1) << other : '0;
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the data RAM between LSU and debug/DMA, with read-modify-write for partial stores
module data_ram_arbiter
    import definitions_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_PORTS-1:0]            req_i,
    input  logic [N_PORTS-1:0]            we_i,
    input  word_ut [N_PORTS-1:0]          addr_i,
    input  word_st [N_PORTS-1:0]          wdata_i,
    input  logic [N_PORTS-1:0][BE_W-1:0]  be_i,
    output logic [N_PORTS-1:0]            gnt_o,
    output logic [N_PORTS-1:0]            rvalid_o,
    output logic [N_PORTS-1:0]            err_o,
    output word_st                        rdata_o,
    output logic                          ram_we_o,
    output word_ut                        ram_a_o,
    output word_st                        ram_wd_o,
    input  word_st                        ram_rd_i
);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] prio_q, sel, port_q;
    logic [N_PORTS-1:0] arb_gnt;
    logic              accept, acc_err, we_q, err_q;
    word_ut            addr_q;
    word_st            wdata_q, merge_q;
    logic [BE_W-1:0]   be_q;

    rr_arbiter u_rr (
        .req  (req_i),
        .prio (prio_q),
        .gnt  (arb_gnt)
    );

    assign sel     = arb_gnt[N_PORTS-1];
    assign accept  = |gnt_o;
    assign acc_err = addr_i[sel] >= word_ut'(DATA_SIZE - 3);

    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // out-of-range and full/empty-lane writes skip the read-modify-write step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = !we_i[sel] ? READ :
                                           (acc_err || be_i[sel] == '0 || &be_i[sel]) ? WRITE : MERGE;
            READ:    state_d = IDLE;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // latch the accepted request, rotate priority, capture merged word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q  <= PORT_W'(RESET_PRIO);
            port_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                prio_q  <= ~sel;
                port_q  <= sel;
                we_q    <= we_i[sel];
                addr_q  <= {addr_i[sel][31:2], 2'b00};
                wdata_q <= wdata_i[sel];
                be_q    <= be_i[sel];
                err_q   <= acc_err;
            end
            if (state_q == MERGE) merge_q <= merge_lanes(be_q, wdata_q, ram_rd_i);
        end
    end

    // outputs decoded from state; everything idles at zero, including during reset
    always_comb begin
        gnt_o    = (rst_ni && state_q == IDLE) ? arb_gnt : '0;
        ram_we_o = state_q == WRITE && we_q && !err_q && be_q != '0;
        ram_a_o  = (state_q != IDLE && !err_q) ? addr_q : '0;
        ram_wd_o = !ram_we_o ? '0 : &be_q ? wdata_q : merge_q;
        rdata_o  = (state_q == READ && !err_q) ? ram_rd_i : '0;
        rvalid_o = (state_q == READ || state_q == WRITE) ? N_PORTS'(1) << port_q : '0;
        err_o    = err_q ? rvalid_o : '0;
    end

endmodule
